// File: rtl/rlh_pkg.sv
// Shared definitions for the run-length histogram.
//   - rlh_state_e : control FSM states (clear sweep, counting, final commit, hold)
//   - Def*        : default values for the NUM_BINS / FRAME_LEN / BIN_W parameters
package rlh_pkg;

  localparam int unsigned DefNumBins  = 16;
  localparam int unsigned DefFrameLen = 1024;
  localparam int unsigned DefBinW     = 10;

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2,
    StDone  = 2'd3
  } rlh_state_e;

endpackage

// File: rtl/rlh_bin_bank.sv
// Histogram bin storage with saturating increment, single-bin clear port and a registered read
// port that bypasses the write performed in the same cycle.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset (zeroes all bins and rd_data)
//   clr_en, clr_addr     zero bin clr_addr this cycle (wins over an increment)
//   inc_en, inc_addr     saturating +1 on bin inc_addr this cycle
//   rd_addr, rd_data     rd_data = bin[rd_addr] as it stands after this clock edge
//   clip                 (RLH_SAT_FLAG_EN only) an increment this cycle hit saturation
module rlh_bin_bank
  import rlh_pkg::*;
#(
  parameter int unsigned NUM_BINS = DefNumBins,
  parameter int unsigned BIN_W    = DefBinW
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr_en,
  input  logic [$clog2(NUM_BINS)-1:0] clr_addr,
  input  logic                        inc_en,
  input  logic [$clog2(NUM_BINS)-1:0] inc_addr,
  input  logic [$clog2(NUM_BINS)-1:0] rd_addr,
  output logic [BIN_W-1:0]            rd_data
`ifdef RLH_SAT_FLAG_EN
  ,
  output logic                        clip
`endif
);

  logic [BIN_W-1:0] bins_q [NUM_BINS];
  logic [BIN_W-1:0] inc_val;
  logic             inc_full;
  logic [BIN_W-1:0] rd_next;

  assign inc_full = &bins_q[inc_addr];
  assign inc_val  = inc_full ? bins_q[inc_addr] : bins_q[inc_addr] + 1'b1;

`ifdef RLH_SAT_FLAG_EN
  assign clip = inc_en && !clr_en && inc_full;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        bins_q[i] <= '0;
      end
    end else if (clr_en) begin
      bins_q[clr_addr] <= '0;
    end else if (inc_en) begin
      bins_q[inc_addr] <= inc_val;
    end
  end

  // Read data reflects the array after this edge, so same-cycle writes are forwarded.
  always_comb begin
    rd_next = bins_q[rd_addr];
    if (clr_en && (clr_addr == rd_addr)) begin
      rd_next = '0;
    end else if (inc_en && (inc_addr == rd_addr)) begin
      rd_next = inc_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next;
    end
  end

endmodule

// File: rtl/run_length_histogram.sv
// Run-length histogram of a serial bit stream. Each frame of FRAME_LEN valid bits is split into
// runs of equal bits; bin k counts runs of length k+1, longer runs land in the last bin.
// Optional feature: define RLH_SAT_FLAG_EN to add the sticky sat_flag output.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (state forced to RUN, bins zeroed)
//   hist_init      start a clear sweep next cycle, aborting any frame in progress
//   data_valid     qualifies data_in; gaps pause the run
//   data_in        serial data bit
//   rd_addr        bin select; rd_data shows bin[rd_addr] one cycle later
//   rd_data        selected bin value
//   busy           high while the clear sweep runs
//   frame_done     one-cycle pulse once the final run of a frame is committed
//   sat_flag       (RLH_SAT_FLAG_EN only) sticky: some increment was clipped
module run_length_histogram
  import rlh_pkg::*;
#(
  parameter int unsigned NUM_BINS  = DefNumBins,
  parameter int unsigned FRAME_LEN = DefFrameLen,
  parameter int unsigned BIN_W     = DefBinW
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        hist_init,
  input  logic                        data_valid,
  input  logic                        data_in,
  input  logic [$clog2(NUM_BINS)-1:0] rd_addr,
  output logic [BIN_W-1:0]            rd_data,
  output logic                        busy,
  output logic                        frame_done
`ifdef RLH_SAT_FLAG_EN
  ,
  output logic                        sat_flag
`endif
);

  localparam int unsigned AddrW = $clog2(NUM_BINS);
  localparam int unsigned RunW  = $clog2(NUM_BINS + 1);
  localparam int unsigned CntW  = $clog2(FRAME_LEN + 1);

  rlh_state_e      state_q, state_d;
  logic [RunW-1:0] run_len_q, run_len_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic            prev_q, prev_d;
  logic [AddrW-1:0] clr_idx_q, clr_idx_d;
  logic            frame_done_d;

  logic            clr_en;
  logic            inc_en;
  logic [AddrW-1:0] run_bin;

  // run_len never exceeds NUM_BINS, so run_len-1 always fits a bin address.
  assign run_bin = AddrW'(run_len_q - RunW'(1));
  assign busy    = (state_q == StClear);

  always_comb begin
    state_d      = state_q;
    run_len_d    = run_len_q;
    bit_cnt_d    = bit_cnt_q;
    prev_d       = prev_q;
    clr_idx_d    = clr_idx_q;
    frame_done_d = 1'b0;
    clr_en       = 1'b0;
    inc_en       = 1'b0;

    if (hist_init) begin
      // Pending run is dropped: no increment is issued this cycle.
      state_d   = StClear;
      run_len_d = '0;
      bit_cnt_d = '0;
      prev_d    = 1'b0;
      clr_idx_d = '0;
    end else begin
      unique case (state_q)
        StClear: begin
          clr_en    = 1'b1;
          clr_idx_d = clr_idx_q + 1'b1;
          if (clr_idx_q == AddrW'(NUM_BINS - 1)) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (data_valid) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            prev_d    = data_in;
            // run_len == 0 marks "no previous bit yet" at the start of a frame.
            if (run_len_q == '0) begin
              run_len_d = RunW'(1);
            end else if (data_in != prev_q) begin
              inc_en    = 1'b1;
              run_len_d = RunW'(1);
            end else if (run_len_q != RunW'(NUM_BINS)) begin
              run_len_d = run_len_q + 1'b1;
            end
            if (bit_cnt_q == CntW'(FRAME_LEN - 1)) begin
              state_d = StFlush;
            end
          end
        end
        StFlush: begin
          inc_en       = 1'b1;
          frame_done_d = 1'b1;
          state_d      = StDone;
        end
        StDone: begin
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      run_len_q  <= '0;
      bit_cnt_q  <= '0;
      prev_q     <= 1'b0;
      clr_idx_q  <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_len_q  <= run_len_d;
      bit_cnt_q  <= bit_cnt_d;
      prev_q     <= prev_d;
      clr_idx_q  <= clr_idx_d;
      frame_done <= frame_done_d;
    end
  end

`ifdef RLH_SAT_FLAG_EN
  logic clip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (hist_init) begin
      sat_flag <= 1'b0;
    end else if (clip) begin
      sat_flag <= 1'b1;
    end
  end
`endif

  rlh_bin_bank #(
    .NUM_BINS (NUM_BINS),
    .BIN_W    (BIN_W)
  ) u_bin_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_en   (clr_en),
    .clr_addr (clr_idx_q),
    .inc_en   (inc_en),
    .inc_addr (run_bin),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
`ifdef RLH_SAT_FLAG_EN
    ,
    .clip     (clip)
`endif
  );

endmodule

// File: tb/tb_run_length_histogram.sv
// Directed bench for run_length_histogram (default parameters, RLH_SAT_FLAG_EN undefined).
// Frames are described by half-period: bit i = ((i / half) % 2 == 0).
module tb_run_length_histogram;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hist_init = 1'b0;
  logic       data_valid = 1'b0;
  logic       data_in = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [9:0] rd_data;
  logic       busy;
  logic       frame_done;

  int total = 0;
  int bad = 0;

  run_length_histogram dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hist_init  (hist_init),
    .data_valid (data_valid),
    .data_in    (data_in),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int half;
    bit gaps;
    bit use_init;
    int b0;
    int c0;
    int b1;
    int c1;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    data_valid = 1'b1;
    data_in    = b;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic send_frame(input int half, input bit gaps, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        repeat ($urandom_range(1, 3)) tick();
      end
      send_bit(((i / half) % 2) == 0);
    end
  endtask

  // Pulse hist_init and measure the clear sweep; bin 0 must read 0 once swept.
  task automatic do_init();
    int n;
    rd_addr   = 4'd0;
    hist_init = 1'b1;
    tick();
    hist_init = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 2) check("clear_read_bin0", int'(rd_data), 0);
      tick();
    end
    check("busy_cycles", n, 16);
  endtask

  // Called right after the FRAME_LEN-th bit was accepted; bits sent in DONE must be ignored.
  task automatic finish_frame();
    check("frame_done_flush", int'(frame_done), 0);
    tick();
    check("frame_done_pulse", int'(frame_done), 1);
    tick();
    check("frame_done_end", int'(frame_done), 0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
  endtask

  task automatic check_bins(input int b0, input int c0, input int b1, input int c1);
    int exp;
    for (int k = 0; k < 16; k++) begin
      exp = (k == b0) ? c0 : ((k == b1) ? c1 : 0);
      rd_addr = k[3:0];
      tick();
      check($sformatf("bin%0d", k), int'(rd_data), exp);
    end
  endtask

  initial begin
    vecs[0] = '{half: 2048, gaps: 0, use_init: 0, b0: 15, c0: 1,    b1: -1, c1: 0};
    vecs[1] = '{half: 16,   gaps: 0, use_init: 1, b0: 15, c0: 64,   b1: -1, c1: 0};
    vecs[2] = '{half: 16,   gaps: 1, use_init: 1, b0: 15, c0: 64,   b1: -1, c1: 0};
    vecs[3] = '{half: 1,    gaps: 0, use_init: 1, b0: 0,  c0: 1023, b1: -1, c1: 0};
    vecs[4] = '{half: 3,    gaps: 0, use_init: 1, b0: 2,  c0: 341,  b1: 0,  c1: 1};
    vecs[5] = '{half: 20,   gaps: 0, use_init: 1, b0: 15, c0: 51,   b1: 3,  c1: 1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_data", int'(rd_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_frame_done", int'(frame_done), 0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].use_init) do_init();
      send_frame(vecs[v].half, vecs[v].gaps, 1024);
      finish_frame();
      check_bins(vecs[v].b0, vecs[v].c0, vecs[v].b1, vecs[v].c1);
    end

    // Runs of 3 with bin 2 watched: count steps on the edge the run closes.
    do_init();
    rd_addr = 4'd2;
    for (int n = 1; n <= 12; n++) begin
      send_bit((((n - 1) / 3) % 2) == 0);
      check($sformatf("bypass_bit%0d", n), int'(rd_data), (n - 1) / 3);
    end

    // Abort at bit 500, then a fresh frame.
    do_init();
    send_frame(16, 1'b0, 500);
    do_init();
    check_bins(-1, 0, -1, 0);
    send_frame(16, 1'b0, 1024);
    finish_frame();
    check_bins(15, 64, -1, 0);

    // Asynchronous reset mid-frame, then a full frame.
    do_init();
    rd_addr = 4'd15;
    send_frame(16, 1'b0, 300);
    check("pre_reset_bin15", int'(rd_data), 18);
    rst_n = 1'b0;
    #1;
    check("async_rd_data", int'(rd_data), 0);
    check("async_busy", int'(busy), 0);
    check("async_frame_done", int'(frame_done), 0);
    tick();
    rst_n = 1'b1;
    send_frame(16, 1'b0, 1024);
    finish_frame();
    check_bins(15, 64, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/run_length_histogram.md
RUN_LENGTH_HISTOGRAM -- requirements
Module: run_length_histogram

Interface
REQ-001 SHALL have parameter NUM_BINS, default 16; run-length bins, bin k counts runs of length k+1.
REQ-002 SHALL have parameter FRAME_LEN, default 1024; valid bits per frame.
REQ-003 SHALL have parameter BIN_W, default 10; width of each bin counter.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port hist_init  in  1  start clear sweep, abort current frame.
REQ-007 SHALL have port data_valid  in  1  data_in qualifier; gaps allowed mid-frame.
REQ-008 SHALL have port data_in  in  1  serial bit.
REQ-009 SHALL have port rd_addr  in  $clog2(NUM_BINS)  bin select.
REQ-010 SHALL have port rd_data  out  BIN_W  selected bin value.
REQ-011 SHALL have port busy  out  1  high during CLEAR.
REQ-012 SHALL have port frame_done  out  1  one-cycle pulse when the histogram is final.

Function
REQ-013 SHALL implement states CLEAR, RUN, FLUSH, DONE.
REQ-014 CLEAR SHALL zero one bin per cycle, bins 0..NUM_BINS-1, then go to RUN; data_valid is ignored in CLEAR.
REQ-015 RUN SHALL count valid bits (bit_cnt) and track current run length (run_len, saturating at NUM_BINS).
REQ-016 On a valid bit differing from the previous valid bit, RUN SHALL increment bin run_len-1 and restart run_len=1.
REQ-017 data_valid low in RUN SHALL pause: run_len, bit_cnt and previous bit are held, and the run continues across the gap.
REQ-018 Runs longer than NUM_BINS SHALL be counted in bin NUM_BINS-1 (clamp).
REQ-019 On the FRAME_LEN-th valid bit, the block SHALL go to FLUSH; FLUSH SHALL commit the final run (including that bit), pulse frame_done, and go to DONE.
REQ-020 DONE SHALL ignore data_valid; only hist_init leaves DONE.
REQ-021 Bin increments SHALL saturate at 2**BIN_W-1.
REQ-022 rd_data SHALL present bin[rd_addr] exactly one cycle after rd_addr, in every state.
REQ-023 If the addressed bin is incremented in the same cycle it is read, rd_data SHALL show the incremented value (bypass).
REQ-024 hist_init in any state SHALL take effect the next cycle: enter CLEAR, zero run_len, bit_cnt and previous bit, and discard the pending run; hist_init during CLEAR restarts the sweep at bin 0.
REQ-025 rd_data during CLEAR SHALL return 0 for bins already swept.

Reset
REQ-026 rst_n low SHALL asynchronously zero all bins, run_len, bit_cnt, rd_data, busy and frame_done, and force RUN.

Configuration
REQ-027 With RLH_SAT_FLAG_EN defined, the block SHALL add output sat_flag (1 bit): sticky, set when any increment is clipped, cleared by rst_n or hist_init.
REQ-028 Without RLH_SAT_FLAG_EN, the sat_flag port and its logic SHALL be absent.

Structure
REQ-029 A package rlh_pkg SHALL hold the state enum and the default parameter constants.
REQ-030 The bin array with saturating increment, clear port and bypassed registered read SHALL be sub-module rlh_bin_bank.

Verification
REQ-031 Reset, then 1024 bits of all-ones, data_valid held high -> frame_done one cycle after the last bit; bin15=1; all other bins 0.
REQ-032 Repeating 16 ones then 16 zeros for 1024 bits -> bin15=64, others 0; the same stream with random data_valid gaps -> identical result.
REQ-033 1024 alternating bits -> bin0=1023 (saturated); with RLH_SAT_FLAG_EN, sat_flag=1.
REQ-034 Runs of length 3, with rd_addr=2 held -> rd_data steps up one cycle after each run closes, with the bypass value on the increment cycle.
REQ-035 hist_init at bit 500 -> busy=1 for 16 cycles, all bins read 0, and a new 1024-bit frame is then histogrammed from scratch.
REQ-036 rst_n asserted mid-frame -> all outputs 0 immediately, and the next 1024 bits form a complete frame.
